// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the boot-loaded data memory controller.
package dmem_ctrl_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MEM_DEPTH  = 256;
  localparam int BOOT_LEN_W = $clog2(MEM_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_ram.sv
// 256x8 storage: one synchronous write port, one combinational read port.
// Contents are never reset.
module dmem_ram
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // single write port; the owner decides who drives it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: loads a program image over the load port while
// holding the CPU in reset, then releases the CPU and serves its active-low
// read/write strobes from the same RAM.
// Optional feature macro: DMEM_WRITE_PROTECT_EN - drops CPU writes into the
// booted region (addr < boot_len) and raises the sticky wp_err output.
//
// state   | meaning
// BOOT    | accepting boot bytes, CPU held in reset
// RELEASE | one-cycle gap after loading, CPU still in reset
// RUN     | CPU running, strobes serviced (terminal until rst)
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int BOOT_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_rst,
  input  logic                  R,
  input  logic                  W,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     mem_in,
  output logic [BOOT_LEN_W-1:0] boot_len,
`ifdef DMEM_WRITE_PROTECT_EN
  output logic                  rw_conflict,
  output logic                  wp_err
`else
  output logic                  rw_conflict
`endif
);

  localparam dmem_state_t RESET_STATE = (BOOT_EN != 0) ? ST_BOOT : ST_RELEASE;

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wptr;
  logic              in_run;
  logic              boot_accept;
  logic              cpu_rd;
  logic              cpu_wr_req;
  logic              cpu_conflict;
  logic              cpu_wr_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign boot_accept  = load_valid & load_ready;
  assign cpu_rd       = in_run & ~R & W;
  assign cpu_wr_req   = in_run & ~W & R;
  assign cpu_conflict = in_run & ~R & ~W;

`ifdef DMEM_WRITE_PROTECT_EN
  logic wr_protected;
  assign wr_protected = ({1'b0, addr} < boot_len);
  assign cpu_wr_ok    = cpu_wr_req & ~wr_protected;
`else
  assign cpu_wr_ok    = cpu_wr_req;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    cpu_rst    = 1'b1;
    in_run     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        load_ready = 1'b1;
        // a byte accepted at the top address ends boot so wptr never wraps
        if (boot_accept && (load_last || wptr == {ADDR_W{1'b1}}))
          state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        cpu_rst = 1'b0;
        in_run  = 1'b1;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // boot write pointer and loaded byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      boot_len <= '0;
    end else if (boot_accept) begin
      wptr     <= wptr + 1'b1;
      boot_len <= boot_len + 1'b1;
    end
  end

  // sticky CPU error flags
  always_ff @(posedge clk) begin
    if (rst) rw_conflict <= 1'b0;
    else if (cpu_conflict) rw_conflict <= 1'b1;
  end

`ifdef DMEM_WRITE_PROTECT_EN
  // sticky flag for writes dropped by the booted-region protection
  always_ff @(posedge clk) begin
    if (rst) wp_err <= 1'b0;
    else if (cpu_wr_req && wr_protected) wp_err <= 1'b1;
  end
`endif

  // write-port mux: boot path and CPU path are mutually exclusive by state;
  // rst blocks any write in its cycle
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr;
    ram_wdata = data_in;
    if (!rst) begin
      if (boot_accept) begin
        ram_we    = 1'b1;
        ram_waddr = wptr;
        ram_wdata = load_data;
      end else if (cpu_wr_ok) begin
        ram_we    = 1'b1;
      end
    end
  end

  dmem_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr),
    .rdata (ram_rdata)
  );

  assign mem_in = cpu_rd ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (BOOT_EN=1) against a behavioural model.
module tb_dmem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       cpu_rst;
  logic       R;
  logic       W;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] mem_in;
  logic [8:0] boot_len;
  logic       rw_conflict;
`ifdef DMEM_WRITE_PROTECT_EN
  logic       wp_err;
`endif

  dmem_ctrl #(.BOOT_EN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_rst     (cpu_rst),
    .R           (R),
    .W           (W),
    .addr        (addr),
    .data_in     (data_in),
    .mem_in      (mem_in),
    .boot_len    (boot_len),
`ifdef DMEM_WRITE_PROTECT_EN
    .rw_conflict (rw_conflict),
    .wp_err      (wp_err)
`else
    .rw_conflict (rw_conflict)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [7:0] ref_mem [256];
  bit         ref_known [256];
  int         ref_wptr;
  int         ref_len;
  bit         ref_conflict;
  bit         ref_wp;
  bit         ref_run;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    R = 1'b1; W = 1'b1; addr = 8'h00; data_in = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_wptr = 0; ref_len = 0; ref_conflict = 1'b0; ref_wp = 1'b0; ref_run = 1'b0;
  endtask

  // offers one byte; returns 1 when the model says boot has ended with it
  task automatic load_byte(input logic [7:0] d, input logic last, output bit ended);
    load_valid = 1'b1; load_data = d; load_last = last;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready_boot got %b want 1", load_ready);
    end
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    ref_mem[ref_wptr] = d; ref_known[ref_wptr] = 1'b1;
    ref_wptr++; ref_len++;
    ended = last || (ref_wptr == 256);
  endtask

  // checks the RELEASE cycle then steps into RUN
  task automatic expect_release(input string tag);
    checks++;
    if (cpu_rst !== 1'b1 || load_ready !== 1'b0 || boot_len !== 9'(ref_len)) begin
      errors++;
      $display("FAIL %s_release cpu_rst=%b load_ready=%b boot_len=%0d want 1 0 %0d",
               tag, cpu_rst, load_ready, boot_len, ref_len);
    end
    tick();
    ref_run = 1'b1;
    checks++;
    if (cpu_rst !== 1'b0 || load_ready !== 1'b0) begin
      errors++; $display("FAIL %s_run cpu_rst=%b load_ready=%b want 0 0", tag, cpu_rst, load_ready);
    end
  endtask

  task automatic cpu_read(input logic [7:0] a, input string tag);
    R = 1'b0; W = 1'b1; addr = a;
    #1;
    checks++;
    if (mem_in !== ref_mem[a]) begin
      errors++; $display("FAIL %s addr=%0d got %h want %h", tag, a, mem_in, ref_mem[a]);
    end
    tick();
    R = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    W = 1'b0; R = 1'b1; addr = a; data_in = d;
    #1;
    checks++;
    if (mem_in !== 8'h00) begin
      errors++; $display("FAIL write_mem_in got %h want 00", mem_in);
    end
    tick();
    W = 1'b1;
    if (ref_run) begin
`ifdef DMEM_WRITE_PROTECT_EN
      if (int'(a) < ref_len) ref_wp = 1'b1;
      else begin ref_mem[a] = d; ref_known[a] = 1'b1; end
`else
      ref_mem[a] = d; ref_known[a] = 1'b1;
`endif
    end
  endtask

  task automatic cpu_conflict(input logic [7:0] a, input logic [7:0] d);
    R = 1'b0; W = 1'b0; addr = a; data_in = d;
    #1;
    checks++;
    if (mem_in !== 8'h00) begin
      errors++; $display("FAIL conflict_mem_in got %h want 00", mem_in);
    end
    tick();
    R = 1'b1; W = 1'b1;
    if (ref_run) ref_conflict = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_rst !== 1'b1 || load_ready !== 1'b1 || mem_in !== 8'h00 ||
        boot_len !== 9'd0 || rw_conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cpu_rst=%b load_ready=%b mem_in=%h boot_len=%0d rw_conflict=%b want 1 1 00 0 0",
               cpu_rst, load_ready, mem_in, boot_len, rw_conflict);
    end
    rst = 1'b0;
    ref_wptr = 0; ref_len = 0; ref_conflict = 1'b0; ref_wp = 1'b0; ref_run = 1'b0;
  endtask

  task automatic test_boot5();
    logic [7:0] img [5];
    bit ended;
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78; img[4] = 8'h9A;
    for (int i = 0; i < 5; i++) load_byte(img[i], i == 4, ended);
    expect_release("boot5");
    R = 1'b0; W = 1'b1; addr = 8'd3;
    #1;
    checks++;
    if (mem_in !== 8'h78) begin
      errors++; $display("FAIL boot5_read3 got %h want 78", mem_in);
    end
    tick();
    R = 1'b1;
  endtask

`ifdef DMEM_WRITE_PROTECT_EN
  task automatic test_write_protect();
    cpu_write(8'd2, ~ref_mem[2]);
    checks++;
    if (wp_err !== 1'b1) begin
      errors++; $display("FAIL wp_err_set got %b want 1", wp_err);
    end
    cpu_read(8'd2, "wp_unchanged");
    cpu_write(8'd5, 8'h5C);
    checks++;
    if (wp_err !== 1'b1) begin
      errors++; $display("FAIL wp_err_hold got %b want 1", wp_err);
    end
    cpu_read(8'd5, "wp_allowed");
  endtask
`endif

  task automatic test_rw();
    cpu_write(8'd10, 8'hAB);
    cpu_read(8'd10, "rw_readback");
    cpu_conflict(8'd10, 8'hCD);
    checks++;
    if (rw_conflict !== 1'b1) begin
      errors++; $display("FAIL rw_conflict_set got %b want 1", rw_conflict);
    end
    cpu_read(8'd10, "rw_suppressed");
    tick();
    checks++;
    if (rw_conflict !== 1'b1) begin
      errors++; $display("FAIL rw_conflict_sticky got %b want 1", rw_conflict);
    end
  endtask

  task automatic test_reset_mid_boot();
    logic [7:0] img [6];
    bit ended;
    do_reset();
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) load_byte(img[i], 1'b0, ended);
    load_valid = 1'b1; load_data = img[3];
    do_reset();
    load_valid = 1'b0;
    checks++;
    if (boot_len !== 9'd0 || load_ready !== 1'b1 || cpu_rst !== 1'b1 || rw_conflict !== 1'b0) begin
      errors++;
      $display("FAIL midboot_reset boot_len=%0d load_ready=%b cpu_rst=%b rw_conflict=%b want 0 1 1 0",
               boot_len, load_ready, cpu_rst, rw_conflict);
    end
    load_byte(~img[0], 1'b0, ended);
    load_byte(~img[1], 1'b1, ended);
    expect_release("midboot");
    for (int a = 0; a < 4; a++) cpu_read(8'(a), "midboot_mem");
  endtask

  task automatic test_stall();
    bit ended;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int stalls = int'($urandom_range(0, 2)) + (i == 1 ? 1 : 0);
      for (int s = 0; s < stalls; s++) begin
        load_valid = 1'b0; load_data = 8'($urandom);
        tick();
        checks++;
        if (boot_len !== 9'(ref_len) || load_ready !== 1'b1) begin
          errors++; $display("FAIL stall_len got %0d/%b want %0d/1", boot_len, load_ready, ref_len);
        end
      end
      load_byte(8'($urandom), i == 5, ended);
      checks++;
      if (boot_len !== 9'(ref_len)) begin
        errors++; $display("FAIL stall_accept_len got %0d want %0d", boot_len, ref_len);
      end
    end
    expect_release("stall");
    for (int a = 0; a < 6; a++) cpu_read(8'(a), "stall_mem");
  endtask

  task automatic test_full_boot();
    bit ended = 1'b0;
    int n = 0;
    do_reset();
    while (!ended && n < 300) begin
      load_byte(8'($urandom), 1'b0, ended);
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL full_boot_count got %0d want 256", n);
    end
    checks++;
    if (boot_len !== 9'd256 || load_ready !== 1'b0) begin
      errors++; $display("FAIL full_boot_end boot_len=%0d load_ready=%b want 256 0", boot_len, load_ready);
    end
    expect_release("full");
    for (int k = 0; k < 8; k++) begin
      int a = (k < 2) ? (k * 255) : int'($urandom_range(0, 255));
      cpu_read(8'(a), "full_mem");
    end
  endtask

  task automatic test_ignore_outside_run();
    bit ended;
    do_reset();
    R = 1'b0; W = 1'b1; addr = 8'd200;
    #1;
    checks++;
    if (mem_in !== 8'h00) begin
      errors++; $display("FAIL boot_read_blocked got %h want 00", mem_in);
    end
    tick();
    R = 1'b1;
    cpu_write(8'd200, ~ref_mem[200]);
    cpu_conflict(8'd200, 8'h11);
    checks++;
    if (rw_conflict !== 1'b0) begin
      errors++; $display("FAIL boot_conflict_ignored got %b want 0", rw_conflict);
    end
    load_byte(8'h3C, 1'b1, ended);
    W = 1'b0; R = 1'b1; addr = 8'd201; data_in = ~ref_mem[201];
    tick();
    W = 1'b1;
    ref_run = 1'b1;
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++; $display("FAIL ignore_run cpu_rst got %b want 0", cpu_rst);
    end
    cpu_read(8'd200, "ignore_boot_wr");
    cpu_read(8'd201, "ignore_release_wr");
    load_valid = 1'b1; load_data = 8'hEE;
    tick();
    load_valid = 1'b0;
    checks++;
    if (boot_len !== 9'd1) begin
      errors++; $display("FAIL run_load_ignored boot_len=%0d want 1", boot_len);
    end
    cpu_read(8'd1, "run_load_mem");
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 300; i++) begin
      int op = int'($urandom_range(0, 19));
      logic [7:0] a = 8'($urandom);
      logic [7:0] d = 8'($urandom);
      if (op < 8)       cpu_read(a, "rand_read");
      else if (op < 17) cpu_write(a, d);
      else if (op < 18) cpu_conflict(a, d);
      else              tick();
      checks++;
      if (rw_conflict !== ref_conflict) begin
        errors++; $display("FAIL rand_conflict got %b want %b", rw_conflict, ref_conflict);
      end
`ifdef DMEM_WRITE_PROTECT_EN
      checks++;
      if (wp_err !== ref_wp) begin
        errors++; $display("FAIL rand_wp_err got %b want %b", wp_err, ref_wp);
      end
`endif
    end
    for (int a = 0; a < 256; a++) if (ref_known[a]) cpu_read(8'(a), "final_sweep");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00; ref_known[i] = 1'b0;
    end
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_boot5();
`ifdef DMEM_WRITE_PROTECT_EN
    test_write_protect();
`endif
    test_rw();
    test_reset_mid_boot();
    test_stall();
    test_full_boot();
    test_ignore_outside_run();
    test_random_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter BOOT_EN, default 1, meaning: 1 = start in BOOT and load the program over the load port; 0 = skip loading, enter RELEASE directly after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 load_valid  in  1  boot byte present.
REQ-005 load_data  in  8  boot byte.
REQ-006 load_last  in  1  marks the final boot byte; qualified by load_valid.
REQ-007 load_ready  out  1  controller accepts a boot byte this cycle.
REQ-008 cpu_rst  out  1  reset to the CPU, active-high.
REQ-009 R  in  1  CPU read strobe, active-low.
REQ-010 W  in  1  CPU write strobe, active-low.
REQ-011 addr  in  8  CPU address.
REQ-012 data_in  in  8  CPU write data (the CPU data_out).
REQ-013 mem_in  out  8  read data to the CPU.
REQ-014 boot_len  out  9  number of bytes loaded, range 0..256.
REQ-015 rw_conflict  out  1  sticky flag: R and W were asserted low in the same cycle.

Function
REQ-016 Storage is a 256x8 array indexed directly by an 8-bit address.
REQ-017 FSM states and transitions:
- BOOT -> RELEASE on the accepted byte that has load_last=1, or on the byte accepted at wptr=255.
- RELEASE -> RUN after exactly 1 cycle.
- RUN is terminal until rst.
REQ-018 load_ready = 1 only in BOOT.
REQ-019 A boot byte is accepted when load_valid & load_ready at posedge:
- mem[wptr] <= load_data;
- wptr <= wptr+1 (8-bit);
- boot_len <= boot_len+1.
REQ-020 Boot wrap-around: the byte accepted at wptr=255 ends boot with boot_len=256; wptr never wraps to 0 inside BOOT.
REQ-021 cpu_rst = 1 in BOOT and RELEASE and 0 in RUN, so the CPU leaves reset one cycle after loading completes.
REQ-022 Reads are combinational in RUN: mem_in = mem[addr] when R=0 and W=1, giving same-cycle data with zero latency. Otherwise mem_in = 8'h00.
REQ-023 In RUN, W=0 and R=1 at posedge writes mem[addr] <= data_in.
REQ-024 Writes are visible to a read of the same address from the next cycle onward.
REQ-025 If R=0 and W=0 in the same RUN cycle:
- the write is suppressed;
- mem_in = 8'h00;
- rw_conflict is set and stays 1 until rst.
REQ-026 The R and W strobes are ignored outside RUN: no write is performed and mem_in = 8'h00.
REQ-027 boot_len holds its value after BOOT exits.

Reset
REQ-028 On rst at posedge, all of the following take effect in that cycle, with rst taking precedence over every other event in the cycle:
- state <= BOOT if BOOT_EN=1, else RELEASE;
- wptr <= 0;
- boot_len <= 0;
- rw_conflict <= 0.
REQ-029 Output values in the reset state:
- cpu_rst=1;
- load_ready = BOOT_EN;
- mem_in=8'h00.
REQ-030 Memory contents are NOT cleared by rst. Reset during BOOT restarts loading at address 0, and already-written bytes remain until they are overwritten.

Configuration
REQ-031 Macro DMEM_WRITE_PROTECT_EN.
- When defined: in RUN, a CPU write with addr < boot_len is dropped, and output wp_err (1 bit, sticky, cleared only by rst) is set.
- When undefined: all RUN writes proceed and the wp_err port does not exist.

Structure
REQ-032 A shared package holds:
- the FSM state encoding (BOOT=2'd0, RELEASE=2'd1, RUN=2'd2);
- the memory depth constant (256);
- the address and data width constants (8).
REQ-033 One sub-module, dmem_ram: a 256x8 array with one synchronous write port and one combinational read port, instantiated once. The boot path and the CPU write path are muxed in front of its single write port.

Verification
REQ-034 Boot of 5 bytes 12,34,56,78,9A with load_last on 9A -> boot_len=5, RELEASE for 1 cycle, then cpu_rst=0; R=0 with addr=3 -> mem_in=78 in the same cycle.
REQ-035 Boot of 256 bytes with no load_last -> automatic exit after byte 255, boot_len=256, load_ready=0 from the next cycle.
REQ-036 In RUN, W=0, addr=10, data_in=AB; next cycle R=0, addr=10 -> mem_in=AB; a read issued in the write cycle itself -> rw_conflict=1, write suppressed, later read of addr 10 returns the prior value.
REQ-037 rst asserted after 3 of 6 boot bytes -> boot_len=0, wptr=0, load_ready=1; reload 2 bytes with last -> addr 2 still holds the earlier third byte.
REQ-038 load_valid toggled 1,0,1 with stalls -> only the cycles with valid=1 increment boot_len; data lands at consecutive addresses.
REQ-039 With DMEM_WRITE_PROTECT_EN, boot_len=5: W=0, addr=2 -> contents unchanged and wp_err=1; addr=5 -> write succeeds and wp_err does not change.
